// File: rtl/iob_sum_master.sv
// iob_sum_master: IOb native initiator that reads a block of 32-bit words,
// accumulates their wrapping two's-complement sum and writes the sum back
// as a single word. At most one request is outstanding at any time.
// All IOb request outputs and status outputs come straight from flops; they
// are loaded from the next-state decode so they line up with the FSM state.
module iob_sum_master #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [ADDR_W-1:0]     dst_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     sum_o,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    input  logic                  iob_rvalid_i,
    input  logic                  iob_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // FSM and datapath state
    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [LEN_W-1:0]    cnt_inc_s;

    // Registered output images
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    assign cnt_inc_s = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Next-state and datapath update; rvalid is only consumed in RD_WAIT
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    dst_d  = dst_addr_i;
                    len_d  = len_i;
                    sum_d  = {DATA_W{1'b0}};
                    cnt_d  = {LEN_W{1'b0}};
                    if (len_i == {LEN_W{1'b0}}) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (iob_ready_i) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                if (iob_rvalid_i) begin
                    sum_d  = sum_q + iob_rdata_i;
                    addr_d = addr_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                    cnt_d  = cnt_inc_s;
                    if (cnt_inc_s == len_q) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                if (iob_ready_i) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs are flops aligned with state
    always_comb begin
        valid_d    = 1'b0;
        req_addr_d = {ADDR_W{1'b0}};
        wdata_d    = {DATA_W{1'b0}};
        wstrb_d    = {STRB_W{1'b0}};
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_RD_REQ: begin
                valid_d    = 1'b1;
                req_addr_d = addr_d;
                busy_d     = 1'b1;
            end
            S_RD_WAIT: begin
                busy_d = 1'b1;
            end
            S_WR_REQ: begin
                valid_d    = 1'b1;
                req_addr_d = dst_d;
                wdata_d    = sum_d;
                wstrb_d    = {STRB_W{1'b1}};
                busy_d     = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; cke_i low freezes everything
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            dst_q      <= {ADDR_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            cnt_q      <= {LEN_W{1'b0}};
            sum_q      <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
            req_addr_q <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wstrb_q    <= {STRB_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (cke_i) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            req_addr_q <= req_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign iob_valid_o = valid_q;
    assign iob_addr_o  = req_addr_q;
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_iob_sum_master.sv
// Directed bench for iob_sum_master: a small IOb memory responder with an
// optional 3-cycle ready stall, request logging and hand-computed results.
module tb_iob_sum_master;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic                clk_i = 1'b0;
    logic                arst_i = 1'b0;
    logic                cke_i = 1'b1;
    logic                start_i = 1'b0;
    logic [ADDR_W-1:0]   base_addr_i = '0;
    logic [ADDR_W-1:0]   dst_addr_i = '0;
    logic [LEN_W-1:0]    len_i = '0;
    logic                busy_o, done_o;
    logic [DATA_W-1:0]   sum_o;
    logic                iob_valid_o;
    logic [ADDR_W-1:0]   iob_addr_o;
    logic [DATA_W-1:0]   iob_wdata_o;
    logic [3:0]          iob_wstrb_o;
    logic [DATA_W-1:0]   iob_rdata_i = '0;
    logic                iob_rvalid_i = 1'b0;
    logic                iob_ready_i = 1'b1;

    iob_sum_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_rdata_i(iob_rdata_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_ready_i(iob_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0]       mem [0:255];
    logic              stall_mode = 1'b0;
    int                wait_c = 0;
    int                acc_cnt = 0;
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] exp_rd_addr = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [3:0]        wr_strb = '0;
    logic [ADDR_W-1:0] held_addr = '0;
    logic [DATA_W-1:0] held_wdata = '0;
    logic [3:0]        held_wstrb = '0;
    logic [DATA_W-1:0] resp_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: drives ready (optionally stalling 3 cycles per request),
    // logs accepted requests and returns read data the cycle after acceptance.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!arst_i) begin
                wait_c = 0;
            end else if (cke_i && iob_valid_o) begin
                if (stall_mode && wait_c > 0) begin
                    check_eq("hold_addr", 64'(iob_addr_o), 64'(held_addr));
                    check_eq("hold_wdata", 64'(iob_wdata_o), 64'(held_wdata));
                    check_eq("hold_wstrb", 64'(iob_wstrb_o), 64'(held_wstrb));
                end
                held_addr  = iob_addr_o;
                held_wdata = iob_wdata_o;
                held_wstrb = iob_wstrb_o;
                if (stall_mode && wait_c < 3) begin
                    iob_ready_i = 1'b0;
                    wait_c++;
                end else begin
                    iob_ready_i = 1'b1;
                    wait_c = 0;
                    acc_cnt++;
                    if (iob_wstrb_o == 4'h0) begin
                        check_eq("rd_addr", 64'(iob_addr_o), 64'(exp_rd_addr));
                        check_eq("rd_wdata", 64'(iob_wdata_o), 64'd0);
                        exp_rd_addr = exp_rd_addr + 24'd4;
                        rd_cnt++;
                        resp_data = mem[iob_addr_o[9:2]];
                        @(posedge clk_i);
                        #1;
                        iob_rvalid_i = 1'b1;
                        iob_rdata_i  = resp_data;
                        @(posedge clk_i);
                        #1;
                        iob_rvalid_i = 1'b0;
                        iob_rdata_i  = 32'h0;
                    end else begin
                        wr_cnt++;
                        wr_addr = iob_addr_o;
                        wr_data = iob_wdata_o;
                        wr_strb = iob_wstrb_o;
                    end
                end
            end
        end
    end

    // Launch one operation and measure edges from start sampling to done_o.
    task automatic run_op(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] dst,
                          input logic [LEN_W-1:0] len, output int lat);
        bit seen;
        @(negedge clk_i);
        acc_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        wr_addr = '0; wr_data = '0; wr_strb = '0;
        exp_rd_addr = base;
        base_addr_i = base; dst_addr_i = dst; len_i = len;
        start_i = 1'b1;
        @(posedge clk_i);
        lat = 1;
        #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i);
            lat++;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("busy_in_done", 64'(busy_o), 64'd0);
            @(negedge clk_i);
            check_eq("done_one_cycle", 64'(done_o), 64'd0);
        end
    endtask

    int  lat;
    bit  saw_valid, saw_done;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[64 + i] = 32'(i + 1);

        // Reset state
        #12;
        check_eq("rst_valid", 64'(iob_valid_o), 64'd0);
        check_eq("rst_addr", 64'(iob_addr_o), 64'd0);
        check_eq("rst_wdata", 64'(iob_wdata_o), 64'd0);
        check_eq("rst_wstrb", 64'(iob_wstrb_o), 64'd0);
        check_eq("rst_busy_done", {62'd0, busy_o, done_o}, 64'd0);
        check_eq("rst_sum", 64'(sum_o), 64'd0);
        @(negedge clk_i);
        arst_i = 1'b1;

        // Sum of 1..8
        run_op(24'h100, 24'h200, 8'd8, lat);
        check_eq("t1_latency", 64'(lat), 64'd18);
        check_eq("t1_sum", 64'(sum_o), 64'd36);
        check_eq("t1_reads", 64'(rd_cnt), 64'd8);
        check_eq("t1_accepted", 64'(acc_cnt), 64'd9);
        check_eq("t1_wr_addr", 64'(wr_addr), 64'h200);
        check_eq("t1_wr_data", 64'(wr_data), 64'd36);
        check_eq("t1_wr_strb", 64'(wr_strb), 64'hF);

        // Same with a 3-cycle ready stall on every request
        stall_mode = 1'b1;
        run_op(24'h100, 24'h200, 8'd8, lat);
        stall_mode = 1'b0;
        iob_ready_i = 1'b1;
        check_eq("t2_latency", 64'(lat), 64'd45);
        check_eq("t2_sum", 64'(sum_o), 64'd36);
        check_eq("t2_accepted", 64'(acc_cnt), 64'd9);
        check_eq("t2_wr_data", 64'(wr_data), 64'd36);
        check_eq("t2_wr_strb", 64'(wr_strb), 64'hF);

        // Wrapping sum: 0x7FFFFFFF + 1 + (-1)
        mem[64] = 32'h7FFF_FFFF; mem[65] = 32'h1; mem[66] = 32'hFFFF_FFFF;
        run_op(24'h100, 24'h200, 8'd3, lat);
        check_eq("t3_latency", 64'(lat), 64'd8);
        check_eq("t3_sum", 64'(sum_o), 64'h7FFF_FFFF);
        check_eq("t3_wr_data", 64'(wr_data), 64'h7FFF_FFFF);

        // Spurious rvalid in IDLE must not touch the held sum
        @(negedge clk_i);
        iob_rvalid_i = 1'b1; iob_rdata_i = 32'h55;
        @(negedge clk_i);
        iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0;
        @(negedge clk_i);
        check_eq("t5_spurious_sum", 64'(sum_o), 64'h7FFF_FFFF);

        // Second start mid-run is ignored
        mem[64] = 32'd10; mem[65] = 32'd20; mem[66] = 32'd30;
        fork
            run_op(24'h100, 24'h208, 8'd3, lat);
            begin
                repeat (5) @(negedge clk_i);
                base_addr_i = 24'h300; dst_addr_i = 24'h400; len_i = 8'd5;
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
        join
        check_eq("t5_sum", 64'(sum_o), 64'd60);
        check_eq("t5_reads", 64'(rd_cnt), 64'd3);
        check_eq("t5_wr_addr", 64'(wr_addr), 64'h208);
        check_eq("t5_wr_data", 64'(wr_data), 64'd60);

        // len 0: a single write of 0
        run_op(24'h100, 24'h204, 8'd0, lat);
        check_eq("t4_latency", 64'(lat), 64'd2);
        check_eq("t4_reads", 64'(rd_cnt), 64'd0);
        check_eq("t4_writes", 64'(wr_cnt), 64'd1);
        check_eq("t4_wr_addr", 64'(wr_addr), 64'h204);
        check_eq("t4_wr_data", 64'(wr_data), 64'd0);
        check_eq("t4_sum", 64'(sum_o), 64'd0);

        // cke low: a start pulse is not sampled
        @(negedge clk_i);
        cke_i = 1'b0;
        base_addr_i = 24'h100; len_i = 8'd2; start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        cke_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq("cke_busy", 64'(busy_o), 64'd0);
        check_eq("cke_valid", 64'(iob_valid_o), 64'd0);

        // Reset during RD_WAIT of word 4
        for (int i = 0; i < 8; i++) mem[64 + i] = 32'(i + 1);
        @(negedge clk_i);
        acc_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        exp_rd_addr = 24'h100;
        base_addr_i = 24'h100; dst_addr_i = 24'h200; len_i = 8'd8;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_cnt >= 4) break;
            @(negedge clk_i);
        end
        check_eq("t6_reached_word4", 64'(rd_cnt), 64'd4);
        @(posedge clk_i);
        #2;
        arst_i = 1'b0;
        #1;
        check_eq("t6_valid", 64'(iob_valid_o), 64'd0);
        check_eq("t6_addr", 64'(iob_addr_o), 64'd0);
        check_eq("t6_busy_done", {62'd0, busy_o, done_o}, 64'd0);
        check_eq("t6_sum", 64'(sum_o), 64'd0);
        check_eq("t6_wdata_wstrb", {28'd0, iob_wstrb_o, iob_wdata_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        arst_i = 1'b1;
        saw_valid = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (iob_valid_o) saw_valid = 1'b1;
            if (done_o) saw_done = 1'b1;
        end
        check_eq("t6_no_valid_after", 64'(saw_valid), 64'd0);
        check_eq("t6_no_done_after", 64'(saw_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_sum_master.md
Name: iob_sum_master

Overview:
IOb native master (initiator) that drives the front-end of the cache/RAM memory wrapper.
- On start: reads LEN consecutive 32-bit words from BASE, accumulates a wrapping two's-complement sum, and writes the sum as one word to DST.
- Used as the reference traffic source for the 8-int-sum flow.
- Keeps at most one request outstanding.

Parameters:
ADDR_W, 24, byte-address width of the IOb front-end (matches FE_ADDR_W)
DATA_W, 32, data width; fixed at 32, strobe width DATA_W/8
LEN_W, 8, width of the word-count input (max 255 words)

Ports:
clk_i  input  1  clock, rising edge
arst_i  input  1  asynchronous reset, active-low
cke_i  input  1  clock enable; low freezes every register
start_i  input  1  single-cycle start pulse, sampled only in IDLE
base_addr_i  input  ADDR_W  byte address of first word, word-aligned
dst_addr_i  input  ADDR_W  byte address of result word, word-aligned
len_i  input  LEN_W  number of words to sum
busy_o  output  1  high from the cycle after start acceptance until DONE exits
done_o  output  1  one-cycle pulse after the result write is accepted
sum_o  output  DATA_W  running/final sum; holds until the next start
iob_valid_o  output  1  request valid
iob_addr_o  output  ADDR_W  request byte address
iob_wdata_o  output  DATA_W  write data
iob_wstrb_o  output  DATA_W/8  write strobe; 0 = read
iob_rdata_i  input  DATA_W  read data
iob_rvalid_i  input  1  read data valid
iob_ready_i  input  1  request accepted when valid & ready

Behaviour:
- Reset (arst_i low, asynchronous):
  - State IDLE.
  - All outputs 0: iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, busy_o, done_o, sum_o.
  - Internal address and count registers 0.
  - Reset mid-transaction abandons the operation. No request is reissued after reset is released.
- cke_i low: no register updates, all outputs hold. Handshakes on such cycles are not counted.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - On start_i=1: latch base_addr_i into addr, dst_addr_i into dst, len_i into len; clear sum and cnt.
  - Go to RD_REQ, or to WR_REQ if len_i==0.
- RD_REQ:
  - iob_valid_o=1, iob_addr_o=addr, iob_wstrb_o=0, iob_wdata_o=0.
  - Request is held stable until iob_ready_i=1, then go to RD_WAIT. iob_valid_o drops in RD_WAIT.
- RD_WAIT:
  - Wait for iob_rvalid_i. Earliest legal arrival is the cycle after acceptance; any wait length is allowed.
  - On rvalid: sum <= sum + iob_rdata_i (mod 2^32, overflow discarded), addr <= addr+4, cnt <= cnt+1.
  - If cnt+1==len go to WR_REQ, else go to RD_REQ.
- WR_REQ:
  - iob_valid_o=1, iob_addr_o=dst, iob_wdata_o=sum, iob_wstrb_o=all ones.
  - Held stable until iob_ready_i; then go to DONE.
  - No rvalid is expected for writes.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- busy_o=1 in RD_REQ, RD_WAIT, WR_REQ.
- start_i outside IDLE is ignored (no re-latch). start_i in the DONE cycle is also ignored.
- iob_rvalid_i outside RD_WAIT is ignored and does not affect sum or cnt.
- Address increment wraps modulo 2^ADDR_W.
- Never more than one outstanding request.
- Throughput: 2 cycles per word with a 1-cycle-latency memory and ready=1.
- Latency, start to done_o: 2*len+2 cycles with ready tied high and rdata one cycle after acceptance.

Test Plan:
- Memory words 1..8 at base 0x100, dst 0x200, len 8, ready=1:
  - 8 reads to addresses 0x100..0x11C, wstrb 0.
  - Then one write to 0x200 with wdata 36, wstrb 0xF.
  - done_o pulses once at cycle 18; sum_o=36.
- Same stimulus with iob_ready_i low for 3 cycles on every request: each request is held with stable addr/wdata/wstrb until accepted; result still 36; exactly 9 accepted requests.
- Words 0x7FFFFFFF, 1, 0xFFFFFFFF (-1), len 3: written sum 0x7FFFFFFF (wrap then recover); no overflow flag.
- len 0: no reads; a single write of 0 to dst; done_o is asserted 2 cycles after start.
- Spurious rvalid in IDLE and a second start_i mid-run: sum and cnt unaffected; the first operation completes with its original base/len/dst.
- arst_i low during RD_WAIT of word 4: all outputs go 0 immediately. After release: no iob_valid_o and no done_o until a new start_i.
